// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants and FSM state encoding for the multi-word add sequencer.
package multiword_add_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : multiword_add_sequencer_pkg

// File: rtl/multiword_add_sequencer_csa.sv
// Combinational W-bit carry-select adder used as the per-slice adder.
// The lower half ripples from cin. The upper half is computed for both
// possible carries, and the lower half's carry-out selects one of them.
module carry_select_adder_nl #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned LO = W / 2;
    localparam int unsigned HI = W - LO;

    generate
        if (W < 2) begin : g_plain
            logic [W:0] full;
            // Too narrow to split, so use a plain add.
            always_comb full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            assign sum  = full[W-1:0];
            assign cout = full[W];
        end else begin : g_csel
            logic [LO:0] lo_r;
            logic [HI:0] hi0;
            logic [HI:0] hi1;
            logic [HI:0] hi_sel;
            // Lower half ripple, plus both speculative upper-half results.
            always_comb begin
                lo_r   = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
                hi0    = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
                hi1    = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};
                hi_sel = lo_r[LO] ? hi1 : hi0;
            end
            assign sum  = {hi_sel[HI-1:0], lo_r[LO-1:0]};
            assign cout = hi_sel[HI];
        end
    endgenerate

endmodule : carry_select_adder_nl

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder front end. It adds two WIDTH*WORDS-bit operands one
// WIDTH-bit slice per cycle, starting with the LSB slice, and keeps the carry
// in a register between slices. Operands and results use valid/ready handshakes.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned WORDS = WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf
);

    localparam int unsigned TOTAL = WIDTH * WORDS;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [TOTAL-1:0]   a_q, a_d;
    logic [TOTAL-1:0]   b_q, b_d;
    logic [TOTAL-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   slice_a;
    logic [WIDTH-1:0]   slice_b;
    logic [WIDTH-1:0]   slice_sum;
    logic               slice_cout;

    // Select the current slice of each captured operand.
    always_comb begin
        slice_a = a_q[WIDTH*idx_q +: WIDTH];
        slice_b = b_q[WIDTH*idx_q +: WIDTH];
    end

    carry_select_adder_nl #(
        .W (WIDTH)
    ) u_slice_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state logic: capture operands, step through the slices, then hold the result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[WIDTH*idx_q +: WIDTH] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    // Signed overflow: the operands have the same sign and the
                    // sum's sign differs from it.
                    ovf_d   = (a_q[TOTAL-1] == b_q[TOTAL-1]) &&
                              (slice_sum[WIDTH-1] != a_q[TOTAL-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset discards any result still in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // out_valid comes straight from the DONE state, so it behaves as a registered output.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule : multiword_add_sequencer
